// File: rtl/stream_decrypt_engine.sv
// Stream decrypt engine: buffers wide input words, serializes them MS byte first and
// applies a bypass / caesar / xor transform chosen through a small register block.
module stream_decrypt_engine #(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 16
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [MST_DWIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  busy,
  output logic [SYS_DWIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  read,
  input  logic                  write,
  input  logic [REG_WIDTH-1:0]  wdata,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  done,
  output logic                  error
);

  localparam int NBYTES = MST_DWIDTH / SYS_DWIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BCNT_W = $clog2(NBYTES + 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_SELECT = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_KEY    = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] ADDR_DROPS  = ADDR_WIDTH'(8'h20);

  localparam logic [1:0] SEL_CAESAR = 2'd1;
  localparam logic [1:0] SEL_XOR    = 2'd2;
  localparam logic [1:0] SEL_RSVD   = 2'd3;

  function automatic logic [SYS_DWIDTH-1:0] decrypt_byte(
    input logic [SYS_DWIDTH-1:0] b,
    input logic [1:0]            sel,
    input logic [SYS_DWIDTH-1:0] key
  );
    logic [SYS_DWIDTH-1:0] res;
    case (sel)
      SEL_CAESAR: res = b - key;
      SEL_XOR:    res = b ^ key;
      default:    res = b;
    endcase
    return res;
  endfunction

  logic [MST_DWIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      count_r, count_nxt_s;
  logic                  busy_r;
  logic                  push_s, pop_s, drop_s;
  logic [MST_DWIDTH-1:0] fifo_head_s;

  logic [MST_DWIDTH-1:0] shift_r;
  logic [BCNT_W-1:0]     left_r;
  logic [1:0]            sel_lat_r;
  logic [SYS_DWIDTH-1:0] key_lat_r;
  logic                  valid_o_r;
  logic [SYS_DWIDTH-1:0] data_o_r;

  logic [1:0]            sel_r, sel_nxt_s;
  logic [REG_WIDTH-1:0]  key_r, key_nxt_s;
  logic [REG_WIDTH-1:0]  drops_r, drops_nxt_s;
  logic [REG_WIDTH-1:0]  rdata_r, rdata_nxt_s;
  logic                  error_nxt_s;
  logic                  done_r, error_r;

  assign fifo_head_s = fifo_mem_r[rd_ptr_r];

  // Handshake decode; a full buffer refuses pushes even when a pop frees a slot this cycle.
  always_comb begin
    push_s = valid_i & ~busy_r;
    drop_s = valid_i & busy_r;
    pop_s  = (~valid_o_r | (left_r == BCNT_W'(0))) & (count_r != CNT_W'(0));
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Word buffer storage and pointers.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      busy_r   <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      busy_r  <= (count_nxt_s == CNT_W'(FIFO_DEPTH));
    end
  end

  // Serializer: the first byte is transformed at the pop with the live SELECT/KEY, which are
  // then latched so later register writes only reach subsequently popped words.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      shift_r   <= '0;
      left_r    <= BCNT_W'(0);
      sel_lat_r <= 2'd0;
      key_lat_r <= '0;
      valid_o_r <= 1'b0;
      data_o_r  <= '0;
    end else if (pop_s) begin
      data_o_r  <= decrypt_byte(fifo_head_s[MST_DWIDTH-1 -: SYS_DWIDTH], sel_r,
                                key_r[SYS_DWIDTH-1:0]);
      shift_r   <= fifo_head_s << SYS_DWIDTH;
      left_r    <= BCNT_W'(NBYTES - 1);
      sel_lat_r <= sel_r;
      key_lat_r <= key_r[SYS_DWIDTH-1:0];
      valid_o_r <= 1'b1;
    end else if (valid_o_r && (left_r != BCNT_W'(0))) begin
      data_o_r  <= decrypt_byte(shift_r[MST_DWIDTH-1 -: SYS_DWIDTH], sel_lat_r, key_lat_r);
      shift_r   <= shift_r << SYS_DWIDTH;
      left_r    <= left_r - BCNT_W'(1);
    end else begin
      valid_o_r <= 1'b0;
      data_o_r  <= '0;
    end
  end

  // Register access decode; a write wins over a simultaneous read.
  always_comb begin
    sel_nxt_s   = sel_r;
    key_nxt_s   = key_r;
    drops_nxt_s = drops_r;
    rdata_nxt_s = rdata_r;
    error_nxt_s = 1'b0;
    if (write) begin
      case (addr)
        ADDR_SELECT: begin
          if (wdata[1:0] == SEL_RSVD) begin
            error_nxt_s = 1'b1;
          end else begin
            sel_nxt_s = wdata[1:0];
          end
        end
        ADDR_KEY:   key_nxt_s   = wdata;
        ADDR_DROPS: error_nxt_s = 1'b1;
        default:    error_nxt_s = 1'b1;
      endcase
    end else if (read) begin
      case (addr)
        ADDR_SELECT: rdata_nxt_s = REG_WIDTH'(sel_r);
        ADDR_KEY:    rdata_nxt_s = key_r;
        ADDR_DROPS: begin
          rdata_nxt_s = drops_r;
          drops_nxt_s = '0;
        end
        default: begin
          rdata_nxt_s = '0;
          error_nxt_s = 1'b1;
        end
      endcase
    end else begin
      error_nxt_s = 1'b0;
    end
    // Clear-on-read happens first, so a coinciding drop leaves the counter at one.
    if (drop_s && (drops_nxt_s != {REG_WIDTH{1'b1}})) begin
      drops_nxt_s = drops_nxt_s + REG_WIDTH'(1);
    end else begin
      drops_nxt_s = drops_nxt_s;
    end
  end

  // Register state and access response.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sel_r   <= 2'd0;
      key_r   <= '0;
      drops_r <= '0;
      rdata_r <= '0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      sel_r   <= sel_nxt_s;
      key_r   <= key_nxt_s;
      drops_r <= drops_nxt_s;
      rdata_r <= rdata_nxt_s;
      done_r  <= read | write;
      error_r <= error_nxt_s;
    end
  end

  assign busy    = busy_r;
  assign valid_o = valid_o_r;
  assign data_o  = data_o_r;
  assign rdata   = rdata_r;
  assign done    = done_r;
  assign error   = error_r;

endmodule
